// File: rtl/mem_sched.sv
// Memory-port scheduler: arbitrates I-refill reads, D reads and posted D writes onto one memory port.
// D writes land in a small circular write buffer that coalesces and forwards, and drains when the port is idle.
module mem_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_read_req,
    input  logic [AW-1:0]          ic_read_addr,
    output logic                   ic_read_ack,
    output logic [DW-1:0]          ic_read_data,
    input  logic                   dc_read_req,
    input  logic [AW-1:0]          dc_read_addr,
    output logic                   dc_read_ack,
    output logic [DW-1:0]          dc_read_data,
    input  logic                   dc_write_req,
    input  logic [AW-1:0]          dc_write_addr,
    input  logic [DW-1:0]          dc_write_data,
    output logic                   dc_write_ack,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic                   mem_ack,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_data_write,
    input  logic [DW-1:0]          mem_data_read,
    output logic [$clog2(DEPTH):0] wb_count,
    output logic                   wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_DC, RD_IC, WR} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] wb_addr [DEPTH];
    logic [DW-1:0] wb_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_addr;

    logic             full;
    logic             empty;
    logic [DEPTH-1:0] entry_vld;
    logic             wr_hit;
    logic [PW-1:0]    wr_idx;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;
    logic [PW-1:0]    scan_idx;
    logic             do_post;
    logic             do_enq;
    logic             do_coal;
    logic             do_pop;
    logic             dc_pend;
    logic             do_fwd;
    logic             dc_miss;
    logic             ic_want;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign wb_count = count;
    assign wb_empty = empty;

    // An entry is live when its distance from head (mod DEPTH) is below the occupancy.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld[i] = ({1'b0, PW'(i) - head} < count);
        end
    end

    // The entry currently on the memory bus must not change under it, so it cannot absorb a write.
    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (wb_addr[i] == dc_write_addr) &&
                !((state == WR) && (PW'(i) == head))) begin
                wr_hit = 1'b1;
                wr_idx = PW'(i);
            end
        end
    end

    // Scan oldest to youngest so the last hit is the most recent value for that address.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if ((CW'(k) < count) && (wb_addr[scan_idx] == dc_read_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[scan_idx];
            end
        end
    end

    assign do_post = dc_write_req && !dc_write_ack && !full;
    assign do_enq  = do_post && !wr_hit;
    assign do_coal = do_post && wr_hit;
    assign do_pop  = (state == WR) && mem_ack;
    assign dc_pend = dc_read_req && !dc_read_ack;
    assign do_fwd  = dc_pend && fwd_hit && (state != RD_DC);
    assign dc_miss = dc_pend && !fwd_hit;
    assign ic_want = ic_read_req && !ic_read_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (full) begin
                    state_nxt = WR;
                end else if (dc_miss) begin
                    state_nxt = RD_DC;
                end else if (ic_want) begin
                    state_nxt = RD_IC;
                end else if (!empty) begin
                    state_nxt = WR;
                end
            end
            RD_DC, RD_IC, WR: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from state so they fall the instant reset is asserted.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_data_write = '0;
        case (state)
            RD_DC, RD_IC: begin
                mem_read = 1'b1;
                mem_addr = rd_addr;
            end
            WR: begin
                mem_write      = 1'b1;
                mem_addr       = wb_addr[head];
                mem_data_write = wb_data[head];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (state_nxt == RD_DC) begin
                rd_addr <= dc_read_addr;
            end else if (state_nxt == RD_IC) begin
                rd_addr <= ic_read_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            wb_addr[tail] <= dc_write_addr;
            wb_data[tail] <= dc_write_data;
        end
        if (do_coal) begin
            wb_data[wr_idx] <= dc_write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            case ({do_enq, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_read_ack  <= 1'b0;
            dc_read_ack  <= 1'b0;
            dc_write_ack <= 1'b0;
        end else begin
            ic_read_ack  <= (state == RD_IC) && mem_ack;
            dc_read_ack  <= ((state == RD_DC) && mem_ack) || do_fwd;
            dc_write_ack <= do_post;
        end
    end

    // Read data registers are cleared too so every output reads 0 while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_read_data <= '0;
            dc_read_data <= '0;
        end else begin
            if ((state == RD_IC) && mem_ack) begin
                ic_read_data <= mem_data_read;
            end
            if ((state == RD_DC) && mem_ack) begin
                dc_read_data <= mem_data_read;
            end else if (do_fwd) begin
                dc_read_data <= fwd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: directed cycle-level scenarios, then random traffic against a
// program-order memory model with a randomly delayed memory responder.
`timescale 1ns/1ps
module tb_mem_sched;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NDA   = 6;
    localparam int NIA   = 8;
    localparam logic [31:0] DA_BASE = 32'h0000_1000;
    localparam logic [31:0] IA_BASE = 32'h0000_2000;

    logic          clk;
    logic          reset;
    logic          ic_read_req;
    logic [AW-1:0] ic_read_addr;
    logic          ic_read_ack;
    logic [DW-1:0] ic_read_data;
    logic          dc_read_req;
    logic [AW-1:0] dc_read_addr;
    logic          dc_read_ack;
    logic [DW-1:0] dc_read_data;
    logic          dc_write_req;
    logic [AW-1:0] dc_write_addr;
    logic [DW-1:0] dc_write_data;
    logic          dc_write_ack;
    logic          mem_read;
    logic          mem_write;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_write;
    logic [DW-1:0] mem_data_read;
    logic [CW-1:0] wb_count;
    logic          wb_empty;

    logic          mem_auto;
    logic          man_ack;
    logic [DW-1:0] man_rdata;
    logic          auto_ack;
    logic [DW-1:0] auto_rdata;

    int n_vec = 0;
    int n_bad = 0;
    int proto_err = 0;
    int rd_cycles = 0;
    logic [31:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] shadow [NDA];

    assign mem_ack       = mem_auto ? auto_ack : man_ack;
    assign mem_data_read = mem_auto ? auto_rdata : man_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
        .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
        .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
        .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
        .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_data_write(mem_data_write),
        .mem_data_read(mem_data_read),
        .wb_count(wb_count), .wb_empty(wb_empty)
    );

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_val(a);
    endfunction

    // Memory observer: logs completed writes and protocol events mid-cycle.
    always @(negedge clk) begin
        if (reset && mem_write && mem_ack) begin
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_data_write);
        end
        if (mem_read && mem_write) proto_err++;
        if (mem_read) rd_cycles++;
    end

    // Random-latency memory used in the random phase.
    initial begin
        int dly;
        dly = 0;
        auto_ack = 1'b0;
        auto_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) begin
                auto_ack = 1'b0;
            end else if (mem_auto && reset && (mem_read || mem_write)) begin
                if (dly == 0) begin
                    auto_ack = 1'b1;
                    if (mem_write) mem_arr[mem_addr] = mem_data_write;
                    else auto_rdata = mem_rd(mem_addr);
                    dly = int'($urandom_range(0, 3));
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post_write(input logic [31:0] a, input logic [31:0] d, input int budget,
                              output int lat);
        dc_write_req = 1'b1;
        dc_write_addr = a;
        dc_write_data = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!dc_write_ack && lat < budget);
        chk("wr_ack", {63'd0, dc_write_ack}, 64'd1);
        dc_write_req = 1'b0;
    endtask

    task automatic dc_read(input logic [31:0] a, input logic [31:0] exp, input int budget);
        int n = 0;
        dc_read_req = 1'b1;
        dc_read_addr = a;
        do begin
            tick();
            n++;
        end while (!dc_read_ack && n < budget);
        chk("dc_rd_ack", {63'd0, dc_read_ack}, 64'd1);
        chk("dc_rd_data", {32'd0, dc_read_data}, {32'd0, exp});
        dc_read_req = 1'b0;
    endtask

    task automatic ic_read(input logic [31:0] a, input logic [31:0] exp, input int budget);
        int n = 0;
        ic_read_req = 1'b1;
        ic_read_addr = a;
        do begin
            tick();
            n++;
        end while (!ic_read_ack && n < budget);
        chk("ic_rd_ack", {63'd0, ic_read_ack}, 64'd1);
        chk("ic_rd_data", {32'd0, ic_read_data}, {32'd0, exp});
        ic_read_req = 1'b0;
    endtask

    task automatic drain_manual();
        int n = 0;
        while (!wb_empty && n < 60) begin
            if (mem_write) begin
                man_ack = 1'b1;
                tick();
                man_ack = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        chk("drain_empty", {63'd0, wb_empty}, 64'd1);
    endtask

    task automatic d_side(input int nops);
        int k;
        int lat;
        logic [31:0] d;
        for (int n = 0; n < nops; n++) begin
            k = int'($urandom_range(0, NDA - 1));
            if ($urandom_range(0, 9) < 6) begin
                d = $urandom;
                post_write(DA_BASE + 32'(4 * k), d, 200, lat);
                shadow[k] = d;
            end else begin
                dc_read(DA_BASE + 32'(4 * k), shadow[k], 200);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic i_side(input int nops);
        logic [31:0] a;
        for (int n = 0; n < nops; n++) begin
            a = IA_BASE + 32'(4 * $urandom_range(0, NIA - 1));
            ic_read(a, init_val(a), 200);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        int lat;
        int base;
        int base_rd;
        int n;
        logic [31:0] a;

        reset = 1'b0;
        ic_read_req = 1'b0;  ic_read_addr = '0;
        dc_read_req = 1'b0;  dc_read_addr = '0;
        dc_write_req = 1'b0; dc_write_addr = '0; dc_write_data = '0;
        mem_auto = 1'b0; man_ack = 1'b0; man_rdata = '0;
        repeat (3) tick();

        chk("rst_ic_ack",  {63'd0, ic_read_ack}, 64'd0);
        chk("rst_dc_ack",  {63'd0, dc_read_ack}, 64'd0);
        chk("rst_wr_ack",  {63'd0, dc_write_ack}, 64'd0);
        chk("rst_mem_rd",  {63'd0, mem_read}, 64'd0);
        chk("rst_mem_wr",  {63'd0, mem_write}, 64'd0);
        chk("rst_addr",    {32'd0, mem_addr}, 64'd0);
        chk("rst_wdata",   {32'd0, mem_data_write}, 64'd0);
        chk("rst_ic_data", {32'd0, ic_read_data}, 64'd0);
        chk("rst_dc_data", {32'd0, dc_read_data}, 64'd0);
        chk("rst_count",   64'(wb_count), 64'd0);
        chk("rst_empty",   {63'd0, wb_empty}, 64'd1);
        reset = 1'b1;
        tick();

        // Posted write then drain.
        dc_write_req = 1'b1; dc_write_addr = 32'h100; dc_write_data = 32'hAA;
        tick();
        chk("t1_ack", {63'd0, dc_write_ack}, 64'd1);
        chk("t1_cnt", 64'(wb_count), 64'd1);
        dc_write_req = 1'b0;
        tick();
        chk("t1_ack_pulse", {63'd0, dc_write_ack}, 64'd0);
        chk("t1_mem_wr", {63'd0, mem_write}, 64'd1);
        chk("t1_addr", {32'd0, mem_addr}, 64'h100);
        chk("t1_data", {32'd0, mem_data_write}, 64'hAA);
        tick();
        chk("t1_hold", {63'd0, mem_write}, 64'd1);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t1_wr_done", {63'd0, mem_write}, 64'd0);
        chk("t1_empty", {63'd0, wb_empty}, 64'd1);

        // Forwarding from the entry being drained.
        base_rd = rd_cycles;
        post_write(32'h200, 32'h11, 5, lat);
        chk("t2_wr_lat", 64'(lat), 64'd1);
        tick();
        chk("t2_in_wr", {63'd0, mem_write}, 64'd1);
        dc_read_req = 1'b1; dc_read_addr = 32'h200;
        tick();
        chk("t2_fwd_ack", {63'd0, dc_read_ack}, 64'd1);
        chk("t2_fwd_data", {32'd0, dc_read_data}, 64'h11);
        dc_read_req = 1'b0;
        tick();
        chk("t2_ack_pulse", {63'd0, dc_read_ack}, 64'd0);
        chk("t2_no_memrd", 64'(rd_cycles), 64'(base_rd));
        drain_manual();

        // Coalescing into a non-draining entry.
        base = wlog_addr.size();
        post_write(32'h300, 32'h1, 5, lat);
        post_write(32'h304, 32'h2, 5, lat);
        post_write(32'h304, 32'h3, 5, lat);
        chk("t3_cnt", 64'(wb_count), 64'd2);
        drain_manual();
        chk("t3_nwr", 64'(wlog_addr.size() - base), 64'd2);
        if (wlog_addr.size() >= base + 2) begin
            chk("t3_a0", {32'd0, wlog_addr[base]}, 64'h300);
            chk("t3_d0", {32'd0, wlog_data[base]}, 64'h1);
            chk("t3_a1", {32'd0, wlog_addr[base+1]}, 64'h304);
            chk("t3_d1", {32'd0, wlog_data[base+1]}, 64'h3);
        end

        // Full buffer back-pressure.
        base = wlog_addr.size();
        for (int i = 0; i < DEPTH; i++) begin
            post_write(32'h400 + 32'(4 * i), 32'h40 + 32'(i), 5, lat);
        end
        chk("t4_full", 64'(wb_count), 64'(DEPTH));
        dc_write_req = 1'b1; dc_write_addr = 32'h400 + 32'(4 * DEPTH); dc_write_data = 32'h4F;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_ack", {63'd0, dc_write_ack}, 64'd0);
        end
        chk("t4_cnt", 64'(wb_count), 64'(DEPTH));
        chk("t4_wr", {63'd0, mem_write}, 64'd1);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t4_ack_wait", {63'd0, dc_write_ack}, 64'd0);
        chk("t4_cnt_pop", 64'(wb_count), 64'(DEPTH - 1));
        tick();
        chk("t4_ack_late", {63'd0, dc_write_ack}, 64'd1);
        chk("t4_cnt_refill", 64'(wb_count), 64'(DEPTH));
        dc_write_req = 1'b0;
        drain_manual();
        chk("t4_nwr", 64'(wlog_addr.size() - base), 64'(DEPTH + 1));
        for (int i = 0; i <= DEPTH; i++) begin
            if (wlog_addr.size() > base + i) begin
                chk("t4_order_a", {32'd0, wlog_addr[base+i]}, 64'(32'h400 + 32'(4 * i)));
                chk("t4_order_d", {32'd0, wlog_data[base+i]},
                    (i == DEPTH) ? 64'h4F : 64'(32'h40 + 32'(i)));
            end
        end

        // Arbitration: D miss, then I read, then buffered write.
        post_write(32'h500, 32'h7, 5, lat);
        ic_read_req = 1'b1; ic_read_addr = 32'h40;
        dc_read_req = 1'b1; dc_read_addr = 32'h80;
        tick();
        chk("t5_rd1", {63'd0, mem_read}, 64'd1);
        chk("t5_rd1_addr", {32'd0, mem_addr}, 64'h80);
        man_rdata = 32'hD0D0; man_ack = 1'b1;
        tick();
        man_ack = 1'b0; man_rdata = '0;
        chk("t5_dc_ack", {63'd0, dc_read_ack}, 64'd1);
        chk("t5_dc_data", {32'd0, dc_read_data}, 64'hD0D0);
        chk("t5_ic_wait", {63'd0, ic_read_ack}, 64'd0);
        chk("t5_idle_gap", {63'd0, mem_read}, 64'd0);
        dc_read_req = 1'b0;
        tick();
        chk("t5_rd2", {63'd0, mem_read}, 64'd1);
        chk("t5_rd2_addr", {32'd0, mem_addr}, 64'h40);
        man_rdata = 32'h1C1C; man_ack = 1'b1;
        tick();
        man_ack = 1'b0; man_rdata = '0;
        chk("t5_ic_ack", {63'd0, ic_read_ack}, 64'd1);
        chk("t5_ic_data", {32'd0, ic_read_data}, 64'h1C1C);
        ic_read_req = 1'b0;
        tick();
        chk("t5_wr", {63'd0, mem_write}, 64'd1);
        chk("t5_wr_addr", {32'd0, mem_addr}, 64'h500);
        chk("t5_wr_data", {32'd0, mem_data_write}, 64'h7);
        drain_manual();

        // Reset in the middle of an I read.
        ic_read_req = 1'b1; ic_read_addr = 32'h44;
        tick();
        chk("t6_in_rd", {63'd0, mem_read}, 64'd1);
        post_write(32'h600, 32'h9, 5, lat);
        chk("t6_cnt_pre", 64'(wb_count), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_drop", {63'd0, mem_read}, 64'd0);
        chk("t6_async_empty", {63'd0, wb_empty}, 64'd1);
        ic_read_req = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        reset = 1'b1;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_ic_ack", {63'd0, ic_read_ack}, 64'd0);
            chk("t6_no_wr", {63'd0, mem_write}, 64'd0);
            tick();
        end
        chk("t6_cnt_post", 64'(wb_count), 64'd0);

        // Random concurrent traffic against the program-order model.
        mem_auto = 1'b1;
        for (int k = 0; k < NDA; k++) shadow[k] = init_val(DA_BASE + 32'(4 * k));
        fork
            d_side(80);
            i_side(40);
        join
        n = 0;
        while (!wb_empty && n < 300) begin
            tick();
            n++;
        end
        chk("rand_drain", {63'd0, wb_empty}, 64'd1);
        repeat (3) tick();
        for (int k = 0; k < NDA; k++) begin
            a = DA_BASE + 32'(4 * k);
            chk("rand_mem", {32'd0, mem_rd(a)}, {32'd0, shadow[k]});
        end
        chk("proto_rd_wr", 64'(proto_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
